lsfr: RTL and testbench

LSFR -- requirements
Module: lsfr

---
 rtl/lsfr.sv | 65 ++++++
 tb/tb_lsfr.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lsfr.sv
// Free-running Fibonacci LFSR. Shifts left one bit per clock and feeds the
// XOR of the tap bits back into the LSB. Taps come from a fixed table of
// maximal-length polynomials, chosen at elaboration time from DATA.
module lsfr #(
    parameter int DATA = 8
) (
    input  logic            clk,
    input  logic            reset,
    output logic [DATA-1:0] out
);

    // Tap masks for each width. Bit p-1 is set for each 1-indexed tap p.
    function automatic logic [15:0] tap_mask16(input int width);
        case (width)
            2:       return 16'h0003; // 2,1
            3:       return 16'h0006; // 3,2
            4:       return 16'h000C; // 4,3
            5:       return 16'h0014; // 5,3
            6:       return 16'h0030; // 6,5
            7:       return 16'h0060; // 7,6
            8:       return 16'h00B8; // 8,6,5,4
            9:       return 16'h0110; // 9,5
            10:      return 16'h0240; // 10,7
            11:      return 16'h0500; // 11,9
            12:      return 16'h0829; // 12,6,4,1
            13:      return 16'h100D; // 13,4,3,1
            14:      return 16'h2015; // 14,5,3,1
            15:      return 16'h6000; // 15,14
            16:      return 16'hD008; // 16,15,13,4
            default: return 16'h0000;
        endcase
    endfunction

    localparam logic [15:0]     TAP_MASK16 = tap_mask16(DATA);
    localparam logic [DATA-1:0] TAP_MASK   = TAP_MASK16[DATA-1:0];

    // Widths outside the tap table have no polynomial; stop elaboration.
    generate
        if (DATA < 2 || DATA > 16) begin : g_bad_width
            $error("lsfr: DATA must be in 2..16");
        end
    endgenerate

    logic [DATA-1:0] s_q;
    logic [DATA-1:0] s_d;
    logic            fb;

    // Feedback is a reduction XOR over constant-masked state bits.
    always_comb begin
        fb  = ^(s_q & TAP_MASK);
        s_d = {s_q[DATA-2:0], fb};
    end

    // State register: reset loads the nonzero seed, otherwise advance one step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s_q <= {{(DATA-1){1'b0}}, 1'b1};
        end else begin
            s_q <= s_d;
        end
    end

    assign out = s_q;

endmodule

// File: tb/tb_lsfr.sv
// Bench for lsfr: a directed DATA=8 vector table (reset hold, first steps,
// mid-sequence reset) followed by full-period histogram runs on five widths.
`timescale 1ns/1ps
module tb_lsfr;

    logic clk;
    logic reset;

    logic [1:0]  out2;
    logic [4:0]  out5;
    logic [7:0]  out8;
    logic [11:0] out12;
    logic [15:0] out16;

    lsfr #(.DATA(2))  dut2  (.clk(clk), .reset(reset), .out(out2));
    lsfr #(.DATA(5))  dut5  (.clk(clk), .reset(reset), .out(out5));
    lsfr #(.DATA(8))  dut8  (.clk(clk), .reset(reset), .out(out8));
    lsfr #(.DATA(12)) dut12 (.clk(clk), .reset(reset), .out(out12));
    lsfr #(.DATA(16)) dut16 (.clk(clk), .reset(reset), .out(out16));

    localparam int NDUT = 5;
    localparam int WIDTHS [NDUT] = '{2, 5, 8, 12, 16};

    logic [15:0] outs [NDUT];
    assign outs[0] = {14'b0, out2};
    assign outs[1] = {11'b0, out5};
    assign outs[2] = {8'b0,  out8};
    assign outs[3] = {4'b0,  out12};
    assign outs[4] = out16;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [19];

    bit seen [NDUT][65536];

    initial begin
        // Each row is one rising edge: reset level applied, out expected after it.
        vecs[0]  = '{1'b0, 8'h01, "rst_hold0"};
        vecs[1]  = '{1'b0, 8'h01, "rst_hold1"};
        vecs[2]  = '{1'b0, 8'h01, "rst_hold2"};
        vecs[3]  = '{1'b1, 8'h02, "seq_02"};
        vecs[4]  = '{1'b1, 8'h04, "seq_04"};
        vecs[5]  = '{1'b1, 8'h08, "seq_08"};
        vecs[6]  = '{1'b1, 8'h11, "seq_11"};
        vecs[7]  = '{1'b1, 8'h23, "seq_23"};
        vecs[8]  = '{1'b1, 8'h47, "seq_47"};
        vecs[9]  = '{1'b1, 8'h8E, "seq_8E"};
        vecs[10] = '{1'b1, 8'h1C, "seq_1C"};
        vecs[11] = '{1'b1, 8'h38, "seq_38"};
        vecs[12] = '{1'b0, 8'h01, "mid_rst"};
        vecs[13] = '{1'b1, 8'h02, "restart_02"};
        vecs[14] = '{1'b1, 8'h04, "restart_04"};
        vecs[15] = '{1'b1, 8'h08, "restart_08"};
        vecs[16] = '{1'b1, 8'h11, "restart_11"};
        vecs[17] = '{1'b0, 8'h01, "mid_rst2"};
        vecs[18] = '{1'b1, 8'h02, "restart2_02"};

        reset = 1'b0;
        for (int i = 0; i < 19; i++) begin
            reset = vecs[i].rst_n;
            @(posedge clk);
            #1;
            check(vecs[i].name, {8'b0, out8}, {8'b0, vecs[i].exp});
        end

        // Full-period runs: reset all widths together, then histogram each.
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++)
            check($sformatf("w%0d_reset", WIDTHS[d]), outs[d], 16'h0001);
        reset = 1'b1;

        begin
            int zero_cnt [NDUT];
            int dup_cnt  [NDUT];
            int miss_cnt [NDUT];
            for (int d = 0; d < NDUT; d++) begin
                zero_cnt[d] = 0;
                dup_cnt[d]  = 0;
                miss_cnt[d] = 0;
            end
            // step k samples the state after k shift edges; step 0 is the seed.
            for (int step = 0; step <= 65535; step++) begin
                if (step > 0) begin
                    @(posedge clk);
                    #1;
                end
                for (int d = 0; d < NDUT; d++) begin
                    int p;
                    p = (1 << WIDTHS[d]) - 1;
                    if (step < p) begin
                        if (outs[d] == 16'h0000)
                            zero_cnt[d]++;
                        else if (seen[d][outs[d]])
                            dup_cnt[d]++;
                        else
                            seen[d][outs[d]] = 1'b1;
                    end else if (step == p) begin
                        check($sformatf("w%0d_wrap_to_seed", WIDTHS[d]), outs[d], 16'h0001);
                    end
                end
            end
            for (int d = 0; d < NDUT; d++) begin
                int p;
                p = (1 << WIDTHS[d]) - 1;
                for (int v = 1; v <= p; v++)
                    if (!seen[d][v]) miss_cnt[d]++;
                check($sformatf("w%0d_zero_seen", WIDTHS[d]), 16'(zero_cnt[d]), 16'h0000);
                check($sformatf("w%0d_duplicates", WIDTHS[d]), 16'(dup_cnt[d]), 16'h0000);
                check($sformatf("w%0d_missing", WIDTHS[d]), 16'(miss_cnt[d]), 16'h0000);
            end
        end

        // After the wrap, DATA=8 must continue with the same sequence.
        // Step 65535 = 257*255, so dut8 is back at the seed now.
        check("w8_after_long_run", {8'b0, out8}, 16'h0001);
        @(posedge clk);
        #1;
        check("w8_repeat_02", {8'b0, out8}, 16'h0002);
        @(posedge clk);
        #1;
        check("w8_repeat_04", {8'b0, out8}, 16'h0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
